// File: rtl/mem_stage_if.sv
// mem_stage_if: word-wide multi-cycle req/ack data-memory port.
//   mem_req   : request, held high until the ack cycle
//   mem_we    : 1 = write, 0 = read; valid while mem_req is high
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data
//   mem_ack   : one-cycle completion strobe from memory
//   mem_rdata : load data, valid with mem_ack
// master = pipeline side (mem_stage), slave = memory side.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage.
//   Consumes the EX/MEM register, issues loads/stores on a req/ack memory
//   port, selects writeback data and registers it into MEM/WB. mem_stall_o
//   freezes upstream stages while an access is being issued or is outstanding.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   flush_i                 kill the instruction currently in MEM
//   result_i, read_data2_i  ALU result / byte address, store data
//   cout_i                  TPU read data
//   wb_sel_i                0/3 = result, 1 = load data, 2 = cout
//   reg_write_enable_i, mem_write_enable_i, reg_write_dst_i
//   mem (mem_stage_if.master)  memory req/ack port
//   mem_stall_o             upstream freeze (combinational)
//   wb_data_o, reg_write_enable_o, reg_write_dst_o   MEM/WB register
//   err_o                   one-cycle timeout pulse
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access after
// TIMEOUT cycles without ack; otherwise err_o is tied low and BUSY waits.
module mem_stage #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic [31:0] result_i,
    input  logic [31:0] read_data2_i,
    input  logic [31:0] cout_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        reg_write_enable_i,
    input  logic        mem_write_enable_i,
    input  logic [4:0]  reg_write_dst_i,
    mem_stage_if.master mem,
    output logic        mem_stall_o,
    output logic [31:0] wb_data_o,
    output logic        reg_write_enable_o,
    output logic [4:0]  reg_write_dst_o,
    output logic        err_o
);

    if (TIMEOUT < 2) begin : g_timeout_range
        $error("mem_stage: TIMEOUT must be >= 2");
    end

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rwe_q, rwe_d;      // captured reg write enable
    logic [4:0]  dst_q, dst_d;      // captured destination
    logic        kill_q, kill_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_we_q, wb_we_d;
    logic [4:0]  wb_dst_q, wb_dst_d;

    logic        access;
    logic        stall;
    logic        timeout;
    logic [31:0] sel_data;

`ifdef MEM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        access   = mem_write_enable_i | (reg_write_enable_i & (wb_sel_i == 2'd1));
        sel_data = (wb_sel_i == 2'd2) ? cout_i : result_i;

        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rwe_d     = rwe_q;
        dst_d     = dst_q;
        kill_d    = kill_q;
        wb_data_d = '0;
        wb_we_d   = 1'b0;
        wb_dst_d  = '0;
        stall     = 1'b0;
        timeout   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        timeout = (cnt_q == 16'(TIMEOUT - 1));
`endif

        case (state_q)
            IDLE: begin
                if (!access) begin
                    wb_data_d = sel_data;
                    wb_we_d   = reg_write_enable_i & ~flush_i;
                    wb_dst_d  = reg_write_dst_i;
                end else if (!flush_i) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = mem_write_enable_i;
                    addr_d  = result_i & ~32'h3;
                    wdata_d = read_data2_i;
                    rwe_d   = reg_write_enable_i;
                    dst_d   = reg_write_dst_i;
                    kill_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d = '0;
`endif
                end
            end
            BUSY: begin
                kill_d = kill_q | flush_i;
                if (mem.mem_ack) begin
                    // A flush in the ack cycle itself still suppresses the write.
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    kill_d    = 1'b0;
                    wb_data_d = we_q ? '0 : mem.mem_rdata;
                    wb_we_d   = rwe_q & ~(kill_q | flush_i);
                    wb_dst_d  = dst_q;
                end else if (timeout) begin
                    // Stall is released in the expiry cycle so the aborted
                    // instruction leaves EX/MEM instead of being reissued.
                    state_d = IDLE;
                    req_d   = 1'b0;
                    kill_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    err_d = 1'b1;
`endif
                end else begin
                    stall = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rwe_q     <= 1'b0;
            dst_q     <= '0;
            kill_q    <= 1'b0;
            wb_data_q <= '0;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rwe_q     <= rwe_d;
            dst_q     <= dst_d;
            kill_q    <= kill_d;
            wb_data_q <= wb_data_d;
            wb_we_q   <= wb_we_d;
            wb_dst_q  <= wb_dst_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign mem.mem_req         = req_q;
    assign mem.mem_we          = we_q;
    assign mem.mem_addr        = addr_q;
    assign mem.mem_wdata       = wdata_q;
    assign mem_stall_o         = stall;
    assign wb_data_o           = wb_data_q;
    assign reg_write_enable_o  = wb_we_q;
    assign reg_write_dst_o     = wb_dst_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage.
//   Table of single-cycle ALU vectors, hand-written load/store/flush/reset
//   (and timeout, when MEM_TIMEOUT_EN is defined) sequences, then a random
//   instruction stream checked against a transaction-level model.
module tb_mem_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] result, rd2, cout;
    logic [1:0]  wb_sel;
    logic        rwe_in, mwe_in;
    logic [4:0]  dst_in;
    logic        stall, rwe_out, err;
    logic [31:0] wb_data;
    logic [4:0]  dst_out;

    always #5 clk = ~clk;

    mem_stage_if mif();

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .flush_i            (flush),
        .result_i           (result),
        .read_data2_i       (rd2),
        .cout_i             (cout),
        .wb_sel_i           (wb_sel),
        .reg_write_enable_i (rwe_in),
        .mem_write_enable_i (mwe_in),
        .reg_write_dst_i    (dst_in),
        .mem                (mif),
        .mem_stall_o        (stall),
        .wb_data_o          (wb_data),
        .reg_write_enable_o (rwe_out),
        .reg_write_dst_o    (dst_out),
        .err_o              (err)
    );

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_nop();
        flush = 1'b0; result = '0; rd2 = '0; cout = '0; wb_sel = 2'd0;
        rwe_in = 1'b0; mwe_in = 1'b0; dst_in = '0;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] res;
        logic [31:0] co;
        logic        rwe;
        logic [4:0]  dst;
        logic        fl;
        logic [31:0] e_data;
        logic        e_we;
        logic [4:0]  e_dst;
    } vec_t;

    vec_t vt[6];

    // One load or store issued from IDLE, acked dly cycles into BUSY.
    // flush_at < 0: no flush; otherwise flush in that BUSY cycle.
    task automatic mem_access(input logic st, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input logic [4:0] d,
                              input int unsigned dly, input int flush_at);
        int unsigned stall_cycles;
        logic        exp_we;
        result = a; rd2 = wd; mwe_in = st; rwe_in = ~st; wb_sel = st ? 2'd0 : 2'd1;
        dst_in = d; flush = 1'b0; cout = 32'h0;
        #1;
        chk("issue_stall", 32'(stall), 32'd1);
        stall_cycles = 1;
        tick();
        for (int unsigned i = 0; i <= dly; i++) begin
            mif.mem_ack   = (i == dly);
            mif.mem_rdata = (i == dly) ? rd : 32'hBAD0BAD0;
            flush         = (int'(i) == flush_at);
            #1;
            chk("busy_req", 32'(mif.mem_req), 32'd1);
            chk("busy_addr", mif.mem_addr, a & ~32'h3);
            chk("busy_we", 32'(mif.mem_we), 32'(st));
            if (st) chk("busy_wdata", mif.mem_wdata, wd);
            chk("busy_stall", 32'(stall), 32'(i != dly));
            if (stall) stall_cycles++;
            tick();
            mif.mem_ack = 1'b0;
            flush = 1'b0;
            if (i < dly) chk("bubble_we", 32'(rwe_out), 32'd0);
        end
        exp_we = ~st & (flush_at < 0);
        chk("done_we", 32'(rwe_out), 32'(exp_we));
        if (exp_we) begin
            chk("done_data", wb_data, rd);
            chk("done_dst", 32'(dst_out), 32'(d));
        end
        chk("done_req", 32'(mif.mem_req), 32'd0);
        chk("stall_cycles", stall_cycles, 1 + dly);
        drive_nop();
    endtask

    // Random-stream model state
    logic        m_busy, m_kill, m_st, m_rwe, acc, ack, prev_stall, exp_stall;
    logic [31:0] m_addr, m_wdata, e_data;
    logic [4:0]  m_dst, e_dst;
    logic        e_we;
    int unsigned m_wait;

    initial begin
        vt[0] = '{2'd0, 32'h0000_1234, 32'h0000_AAAA, 1'b1, 5'd5,  1'b0, 32'h0000_1234, 1'b1, 5'd5};
        vt[1] = '{2'd2, 32'h0000_0001, 32'h00C0_FFEE, 1'b1, 5'd7,  1'b0, 32'h00C0_FFEE, 1'b1, 5'd7};
        vt[2] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b1, 5'd31};
        vt[3] = '{2'd0, 32'h0000_0055, 32'h0000_0000, 1'b0, 5'd3,  1'b0, 32'h0,         1'b0, 5'd0};
        vt[4] = '{2'd2, 32'h0000_0000, 32'h0000_0077, 1'b1, 5'd9,  1'b1, 32'h0,         1'b0, 5'd0};
        vt[5] = '{2'd1, 32'h0000_0099, 32'h0000_0000, 1'b0, 5'd2,  1'b0, 32'h0,         1'b0, 5'd0};

        rst_n = 1'b0;
        drive_nop();
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        #12;
        chk("rst_req", 32'(mif.mem_req), 32'd0);
        chk("rst_we", 32'(mif.mem_we), 32'd0);
        chk("rst_addr", mif.mem_addr, 32'd0);
        chk("rst_wdata", mif.mem_wdata, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_we", 32'(rwe_out), 32'd0);
        chk("rst_wb_dst", 32'(dst_out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        tick();

        // ALU / non-memory vectors: one-cycle latency, never stall
        for (int unsigned k = 0; k < 6; k++) begin
            wb_sel = vt[k].sel; result = vt[k].res; cout = vt[k].co; rwe_in = vt[k].rwe;
            dst_in = vt[k].dst; flush = vt[k].fl; mwe_in = 1'b0; rd2 = '0;
            #1;
            chk("alu_stall", 32'(stall), 32'd0);
            tick();
            chk("alu_we", 32'(rwe_out), 32'(vt[k].e_we));
            if (vt[k].e_we) begin
                chk("alu_data", wb_data, vt[k].e_data);
                chk("alu_dst", 32'(dst_out), 32'(vt[k].e_dst));
            end
        end
        drive_nop();

        // Load from 0x103, ack three cycles after req
        mem_access(1'b0, 32'h0000_0103, 32'h0, 32'h5A5A_1234, 5'd4, 3, -1);
        // Store, ack immediate
        mem_access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 5'd0, 0, -1);
        // Flushed load while BUSY: still completes, no writeback
        mem_access(1'b0, 32'h0000_0200, 32'h0, 32'h0000_BEEF, 5'd6, 2, 1);
        // Flush landing in the ack cycle itself
        mem_access(1'b0, 32'h0000_0304, 32'h0, 32'h1111_2222, 5'd8, 1, 1);
        // Next instruction proceeds normally
        wb_sel = 2'd0; result = 32'h0000_0ABC; rwe_in = 1'b1; dst_in = 5'd10;
        tick();
        chk("post_flush_we", 32'(rwe_out), 32'd1);
        chk("post_flush_data", wb_data, 32'h0000_0ABC);
        drive_nop();

        // Flush of a memory op while IDLE: no request, no stall
        result = 32'h80; wb_sel = 2'd1; rwe_in = 1'b1; dst_in = 5'd3; flush = 1'b1;
        #1;
        chk("idle_flush_stall", 32'(stall), 32'd0);
        tick();
        chk("idle_flush_req", 32'(mif.mem_req), 32'd0);
        chk("idle_flush_we", 32'(rwe_out), 32'd0);
        drive_nop();

        // Reset while BUSY: request drops asynchronously, late ack ignored
        result = 32'h0000_0444; wb_sel = 2'd1; rwe_in = 1'b1; dst_in = 5'd12;
        tick();
        chk("pre_rst_req", 32'(mif.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        drive_nop();
        #1;
        chk("async_rst_req", 32'(mif.mem_req), 32'd0);
        chk("async_rst_addr", mif.mem_addr, 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 32'hFEED_FACE;
        #1;
        chk("late_ack_stall", 32'(stall), 32'd0);
        tick();
        mif.mem_ack = 1'b0;
        chk("late_ack_req", 32'(mif.mem_req), 32'd0);
        chk("late_ack_we", 32'(rwe_out), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Load with no ack: abort after TMO BUSY cycles
        result = 32'h0000_0500; wb_sel = 2'd1; rwe_in = 1'b1; dst_in = 5'd13;
        tick();
        for (int unsigned i = 0; i < TMO; i++) begin
            #1;
            chk("tmo_req", 32'(mif.mem_req), 32'd1);
            chk("tmo_stall", 32'(stall), 32'(i != TMO - 1));
            chk("tmo_err_low", 32'(err), 32'd0);
            tick();
            if (i == TMO - 1) drive_nop();
        end
        chk("tmo_req_drop", 32'(mif.mem_req), 32'd0);
        chk("tmo_err_pulse", 32'(err), 32'd1);
        chk("tmo_bubble", 32'(rwe_out), 32'd0);
        tick();
        chk("tmo_err_single", 32'(err), 32'd0);
`endif

        // Random stream against transaction-level model
        m_busy = 1'b0; m_kill = 1'b0; m_wait = 0; prev_stall = 1'b0;
        m_st = 1'b0; m_rwe = 1'b0; m_addr = '0; m_wdata = '0; m_dst = '0;
        e_we = 1'b0; e_data = '0; e_dst = '0;
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin
                chk("rnd_wb_we", 32'(rwe_out), 32'(e_we));
                if (e_we) begin
                    chk("rnd_wb_data", wb_data, e_data);
                    chk("rnd_wb_dst", 32'(dst_out), 32'(e_dst));
                end
            end
            if (!prev_stall) begin
                result = $urandom; rd2 = $urandom; cout = $urandom;
                wb_sel = 2'($urandom_range(0, 3));
                rwe_in = 1'($urandom_range(0, 1));
                mwe_in = ($urandom_range(0, 3) == 0);
                dst_in = 5'($urandom_range(0, 31));
            end
            flush = ($urandom_range(0, 9) == 0);
            acc = mwe_in | (rwe_in & (wb_sel == 2'd1));
            ack = m_busy && (m_wait == 0);
            mif.mem_ack = ack;
            mif.mem_rdata = $urandom;
            #1;
            exp_stall = m_busy ? ~ack : (acc & ~flush);
            chk("rnd_stall", 32'(stall), 32'(exp_stall));
            chk("rnd_req", 32'(mif.mem_req), 32'(m_busy));
            chk("rnd_err", 32'(err), 32'd0);
            if (m_busy) begin
                chk("rnd_addr", mif.mem_addr, m_addr);
                chk("rnd_mwe", 32'(mif.mem_we), 32'(m_st));
                if (m_st) chk("rnd_wdata", mif.mem_wdata, m_wdata);
            end
            e_we = 1'b0; e_data = '0; e_dst = '0;
            if (m_busy) begin
                m_kill = m_kill | flush;
                if (ack) begin
                    m_busy = 1'b0;
                    e_we   = m_rwe & ~m_kill;
                    e_data = m_st ? 32'h0 : mif.mem_rdata;
                    e_dst  = m_dst;
                end else begin
                    m_wait--;
                end
            end else if (!acc) begin
                e_we   = rwe_in & ~flush;
                e_data = (wb_sel == 2'd2) ? cout : result;
                e_dst  = dst_in;
            end else if (!flush) begin
                m_busy  = 1'b1;
                m_kill  = 1'b0;
                m_wait  = $urandom_range(0, 3);
                m_st    = mwe_in;
                m_rwe   = rwe_in;
                m_addr  = {result[31:2], 2'b00};
                m_wdata = rd2;
                m_dst   = dst_in;
            end
            prev_stall = exp_stall;
            tick();
            mif.mem_ack = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
